// File: rtl/mux_16_to_1_pkg.sv
// Shared constants and a lane-extraction helper for the registered 16-to-1 selector.
package mux_16_to_1_pkg;

  localparam int unsigned N_LANES    = 16;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned LANE_MAX_W = 32;

  // Returns lane idx of a packed bus whose lanes are width bits wide (width <= LANE_MAX_W).
  function automatic logic [LANE_MAX_W-1:0] lane_of(
    input logic [N_LANES*LANE_MAX_W-1:0] bus,
    input int unsigned                   width,
    input logic [SEL_W-1:0]              idx
  );
    logic [N_LANES*LANE_MAX_W-1:0] sh;
    logic [LANE_MAX_W-1:0]         r;
    sh = bus >> (32'(idx) * width);
    r  = '0;
    for (int unsigned i = 0; i < LANE_MAX_W; i++) begin
      if (i < width) r[i] = sh[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_16_to_1_mux_2_1.sv
// Purely combinational 2:1 selector used as the leaf of the 16-to-1 tree.
module mux_2_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = s ? b : a;
  end

endmodule

// File: rtl/mux_16_to_1.sv
// Registered 16-to-1 lane selector built from a 4-level 2:1 tree with a valid qualifier.
// Optional even-parity output enabled by defining MUX_16_TO_1_PARITY_EN.
module mux_16_to_1
  import mux_16_to_1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [16*WIDTH-1:0]  in,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out,
  output logic                 out_vld
`ifdef MUX_16_TO_1_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  logic [WIDTH-1:0] l0 [N_LANES];
  logic [WIDTH-1:0] l1 [8];
  logic [WIDTH-1:0] l2 [4];
  logic [WIDTH-1:0] l3 [2];
  logic [WIDTH-1:0] lane;

  for (genvar k = 0; k < 16; k++) begin : g_unpack
    assign l0[k] = in[k*WIDTH +: WIDTH];
  end

  // Level n of the tree is steered by sel[n]; pairs are adjacent lanes.
  for (genvar i = 0; i < 8; i++) begin : g_lvl0
    mux_2_1 #(.WIDTH(WIDTH)) u_mux (.a(l0[2*i]), .b(l0[2*i+1]), .s(sel[0]), .y(l1[i]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_lvl1
    mux_2_1 #(.WIDTH(WIDTH)) u_mux (.a(l1[2*i]), .b(l1[2*i+1]), .s(sel[1]), .y(l2[i]));
  end

  for (genvar i = 0; i < 2; i++) begin : g_lvl2
    mux_2_1 #(.WIDTH(WIDTH)) u_mux (.a(l2[2*i]), .b(l2[2*i+1]), .s(sel[2]), .y(l3[i]));
  end

  mux_2_1 #(.WIDTH(WIDTH)) u_lvl3 (.a(l3[0]), .b(l3[1]), .s(sel[3]), .y(lane));

  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) out <= lane;
    end
  end

`ifdef MUX_16_TO_1_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (in_vld) begin
      out_par <= ^lane;
    end
  end
`endif

endmodule

// File: tb/tb_mux_16_to_1.sv
// Directed self-checking bench for mux_16_to_1 at WIDTH=1 and WIDTH=8 sharing one clock.
module tb_mux_16_to_1;
  import mux_16_to_1_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_vld;
  logic [3:0]     sel;
  logic [15:0]    in1;
  logic [127:0]   in8;
  logic [0:0]     out1;
  logic [7:0]     out8;
  logic           vld1;
  logic           vld8;
`ifdef MUX_16_TO_1_PARITY_EN
  logic           par1;
  logic           par8;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  mux_16_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in1), .sel(sel),
    .out(out1), .out_vld(vld1)
`ifdef MUX_16_TO_1_PARITY_EN
    , .out_par(par1)
`endif
  );

  mux_16_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in8), .sel(sel),
    .out(out8), .out_vld(vld8)
`ifdef MUX_16_TO_1_PARITY_EN
    , .out_par(par8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N_LANES*LANE_MAX_W-1:0] bus;
    logic [3:0] bits [4];

    rst    = 1'b1;
    in_vld = 1'b1;
    sel    = 4'h3;
    in1    = 16'hFFFF;
    for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'h10 + 8'(k);

    // Reset holds outputs low despite in_vld=1
    step();
    check("rst1_out1", 32'(out1), 32'h0);
    check("rst1_vld1", 32'(vld1), 32'h0);
    check("rst1_out8", 32'(out8), 32'h00);
    step();
    check("rst2_out1", 32'(out1), 32'h0);
    check("rst2_vld8", 32'(vld8), 32'h0);
`ifdef MUX_16_TO_1_PARITY_EN
    check("rst2_par8", 32'(par8), 32'h0);
`endif

    // First edge after release samples normally
    rst = 1'b0;
    step();
    check("rel_out1", 32'(out1), 32'h1);
    check("rel_vld1", 32'(vld1), 32'h1);
    check("rel_out8", 32'(out8), 32'h13);

    // Basic select on 16'h3f0a
    in1 = 16'h3f0a;
    sel = 4'h0; step(); check("bas_s0", 32'(out1), 32'h0);
    sel = 4'h1; step(); check("bas_s1", 32'(out1), 32'h1);
    sel = 4'h6; step(); check("bas_s6", 32'(out1), 32'h0);
    sel = 4'hC; step(); check("bas_sC", 32'(out1), 32'h1);

    // Exhaustive back-to-back sweep
    bus = '0;
    bus[15:0] = 16'h3f0a;
    for (int s = 0; s < 16; s++) begin
      sel = 4'(s);
      step();
      check($sformatf("exh_out1_%0d", s), 32'(out1), 32'(lane_of(bus, 1, 4'(s))));
      check($sformatf("exh_vld1_%0d", s), 32'(vld1), 32'h1);
      check($sformatf("exh_out8_%0d", s), 32'(out8), 32'h10 + 32'(s));
    end

    // Wide lanes and parity
    sel = 4'hF; step();
    check("wide_sF", 32'(out8), 32'h1F);
`ifdef MUX_16_TO_1_PARITY_EN
    check("par_1F", 32'(par8), 32'h1);
`endif
    sel = 4'h0; step();
    check("wide_s0", 32'(out8), 32'h10);
`ifdef MUX_16_TO_1_PARITY_EN
    check("par_10", 32'(par8), 32'h1);
`endif

    // Hold: load sel=1 then drop in_vld with scrambled inputs
    sel = 4'h1; step();
    check("hold_load1", 32'(out1), 32'h1);
    check("hold_load8", 32'(out8), 32'h11);
`ifdef MUX_16_TO_1_PARITY_EN
    check("par_11", 32'(par8), 32'h0);
`endif
    in_vld = 1'b0;
    sel    = 4'h0;
    in1    = 16'h0000;
    in8    = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("hold_out1_%0d", c), 32'(out1), 32'h1);
      check($sformatf("hold_vld1_%0d", c), 32'(vld1), 32'h0);
      check($sformatf("hold_out8_%0d", c), 32'(out8), 32'h11);
`ifdef MUX_16_TO_1_PARITY_EN
      check($sformatf("hold_par8_%0d", c), 32'(par8), 32'h0);
`endif
    end

    // Reset mid-stream discards the pending sample
    in1    = 16'h3f0a;
    for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'h10 + 8'(k);
    in_vld = 1'b1;
    sel    = 4'hF;
    step();
    check("mid_pre_out8", 32'(out8), 32'h1F);
    rst = 1'b1;
    step();
    check("mid_rst_out8", 32'(out8), 32'h00);
    check("mid_rst_vld8", 32'(vld8), 32'h0);
    check("mid_rst_out1", 32'(out1), 32'h0);
`ifdef MUX_16_TO_1_PARITY_EN
    check("mid_rst_par8", 32'(par8), 32'h0);
`endif
    rst = 1'b0;
    sel = 4'h9;
    step();
    check("post_out1", 32'(out1), 32'h1);
    check("post_out8", 32'(out8), 32'h19);
    check("post_vld8", 32'(vld8), 32'h1);
`ifdef MUX_16_TO_1_PARITY_EN
    check("post_par8", 32'(par8), 32'h1);
`endif

    bits[0] = 4'h0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
